// File: rtl/d2f_hazard_ctrl.sv
// Decode-to-fetch feedback controller: turns decode-stage hazard, branch and halt events into fetch-stage controls.
// Latency: each response appears one cycle after the sampling edge; stall lasts STALL_CYCLES and flush lasts FLUSH_CYCLES.
// Backpressure: while stalling, flushing or halted, the block ignores decode events. It accepts the next event on the RUN-return cycle.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   validD            decode holds a live instruction (qualifies the events)
//   hazardD           load-use hazard in decode
//   brTakenD          branch/jump resolved taken; brTargetD is its target
//   haltD             HALT decoded
//   stallF            hold PC and fetch/decode latch
//   flushF2D          load NOP bubble into fetch/decode latch
//   redirectF         fetch loads redirectPCF on the next edge (first flush cycle only)
//   redirectPCF       captured redirect target, stable until the next capture
//   haltF             sticky halt indication
//   stateO            current state (RUN=0, STALL=1, REDIRECT=2, HALT=3)
// Optional (D2F_HAZARD_STATS_EN): stallCntO / flushCntO are saturating counts of stall and redirect entries.
module d2f_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int PC_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validD,
  input  logic            hazardD,
  input  logic            brTakenD,
  input  logic [PC_W-1:0] brTargetD,
  input  logic            haltD,
  output logic            stallF,
  output logic            flushF2D,
  output logic            redirectF,
  output logic [PC_W-1:0] redirectPCF,
  output logic            haltF,
  output logic [1:0]      stateO
`ifdef D2F_HAZARD_STATS_EN
  ,
  output logic [15:0]     stallCntO,
  output logic [15:0]     flushCntO
`endif
);

  if (STALL_CYCLES < 1 || STALL_CYCLES > 15 ||
      FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || PC_W < 1) begin : g_param_check
    $error("d2f_hazard_ctrl: STALL_CYCLES must be 1..15, FLUSH_CYCLES 1..3, PC_W >= 1");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  // The counter is loaded with the duration minus one, so a stall or flush lasts until the counter reaches zero.
  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] tgt_q, tgt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      RUN: begin
        if (validD) begin
          if (haltD) begin
            state_d = HALT;
          end else if (brTakenD) begin
            state_d = REDIRECT;
            cnt_d   = FLUSH_INIT;
            tgt_d   = brTargetD;
          end else if (hazardD) begin
            state_d = STALL;
            cnt_d   = STALL_INIT;
          end
        end
      end
      STALL, REDIRECT: begin
        if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Outputs depend only on registered state, counter and target.
  assign stallF      = (state_q == STALL) || (state_q == HALT);
  assign flushF2D    = (state_q == REDIRECT);
  // The counter still holds its load value only in the first REDIRECT cycle.
  assign redirectF   = (state_q == REDIRECT) && (cnt_q == FLUSH_INIT);
  assign redirectPCF = tgt_q;
  assign haltF       = (state_q == HALT);
  assign stateO      = state_q;

`ifdef D2F_HAZARD_STATS_EN
  logic stall_entry, flush_entry;
  assign stall_entry = (state_q == RUN) && (state_d == STALL);
  assign flush_entry = (state_q == RUN) && (state_d == REDIRECT);

  // Entries come only from RUN, so the counters hold still in HALT without extra gating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCntO <= 16'd0;
      flushCntO <= 16'd0;
    end else begin
      if (stall_entry && stallCntO != 16'hFFFF) stallCntO <= stallCntO + 16'd1;
      if (flush_entry && flushCntO != 16'hFFFF) flushCntO <= flushCntO + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d2f_hazard_ctrl.sv
// Randomised bench for d2f_hazard_ctrl, checked against a per-cycle expected-response queue model.
// Latency: the model predicts outputs for the cycle following each sampling edge.
// Backpressure: the model accepts an event only when no response is pending and the processor is not halted.
module tb_d2f_hazard_ctrl;
  localparam int S  = 4;
  localparam int F  = 2;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          validD, hazardD, brTakenD, haltD;
  logic [PW-1:0] brTargetD;
  logic          stallF, flushF2D, redirectF, haltF;
  logic [PW-1:0] redirectPCF;
  logic [1:0]    stateO;
`ifdef D2F_HAZARD_STATS_EN
  logic [15:0]   stallCntO, flushCntO;
`endif

  always #5 clk = ~clk;

  d2f_hazard_ctrl #(.STALL_CYCLES(S), .FLUSH_CYCLES(F), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .validD(validD), .hazardD(hazardD),
    .brTakenD(brTakenD), .brTargetD(brTargetD), .haltD(haltD),
    .stallF(stallF), .flushF2D(flushF2D), .redirectF(redirectF),
    .redirectPCF(redirectPCF), .haltF(haltF), .stateO(stateO)
`ifdef D2F_HAZARD_STATS_EN
    , .stallCntO(stallCntO), .flushCntO(flushCntO)
`endif
  );

  // Expected outputs for one cycle.
  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       redir;
    logic [1:0] st;
  } exp_t;

  localparam exp_t IDLE = '{stall: 1'b0, flush: 1'b0, redir: 1'b0, st: 2'd0};
  localparam exp_t HLT  = '{stall: 1'b1, flush: 1'b0, redir: 1'b0, st: 2'd3};

  exp_t          pend[$];
  exp_t          cur;
  logic          halted;
  logic [PW-1:0] tgt_m;
  int            stall_entries, flush_entries;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    cur           = IDLE;
    halted        = 1'b0;
    tgt_m         = '0;
    stall_entries = 0;
    flush_entries = 0;
  endtask

  // Called at each rising edge with the inputs that the DUT has just sampled.
  task automatic model_edge();
    exp_t e;
    if (!rst) begin
      model_reset();
      return;
    end
    if (cur.st == 2'd0 && !halted && validD) begin
      if (haltD) begin
        halted = 1'b1;
      end else if (brTakenD) begin
        tgt_m = brTargetD;
        for (int i = 0; i < F; i++) begin
          e = '{stall: 1'b0, flush: 1'b1, redir: (i == 0), st: 2'd2};
          pend.push_back(e);
        end
        if (flush_entries < 65535) flush_entries++;
      end else if (hazardD) begin
        for (int i = 0; i < S; i++) begin
          e = '{stall: 1'b1, flush: 1'b0, redir: 1'b0, st: 2'd1};
          pend.push_back(e);
        end
        if (stall_entries < 65535) stall_entries++;
      end
    end
    if (halted)               cur = HLT;
    else if (pend.size() > 0) cur = pend.pop_front();
    else                      cur = IDLE;
  endtask

  task automatic check_all();
    check("stallF",      32'(stallF),      32'(cur.stall));
    check("flushF2D",    32'(flushF2D),    32'(cur.flush));
    check("redirectF",   32'(redirectF),   32'(cur.redir));
    check("haltF",       32'(haltF),       32'(halted));
    check("redirectPCF", 32'(redirectPCF), 32'(tgt_m));
    check("stateO",      32'(stateO),      32'(cur.st));
`ifdef D2F_HAZARD_STATS_EN
    check("stallCntO",   32'(stallCntO),   32'(stall_entries));
    check("flushCntO",   32'(flushCntO),   32'(flush_entries));
`endif
  endtask

  task automatic set_in(input logic v, input logic hz, input logic br,
                        input logic [PW-1:0] tg, input logic ht);
    validD    = v;
    hazardD   = hz;
    brTakenD  = br;
    brTargetD = tg;
    haltD     = ht;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Drop reset away from the clock edge. Outputs must clear before the next edge.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    rst = 1'b1;
  endtask

  task automatic rand_inputs();
    set_in(($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 3),
           ($urandom_range(9, 0) < 2), PW'($urandom), ($urandom_range(199, 0) == 0));
  endtask

  int halt_age;

  initial begin
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle after reset.
    repeat (10) cycle();
    check("idle_pc", 32'(redirectPCF), 32'h0);

    // Single hazard pulse.
    set_in(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (S + 2) cycle();

    // A branch, then a second branch while flushing, which must be ignored.
    set_in(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
    cycle();
    check("br_first_redir", 32'(redirectF), 32'h1);
    set_in(1'b1, 1'b0, 1'b1, 16'h0080, 1'b0);
    cycle();
    check("br_second_nored", 32'(redirectF), 32'h0);
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) cycle();
    check("br_pc_hold", 32'(redirectPCF), 32'h0040);

    // Hazards held high continuously: re-accepted on every RUN-return cycle.
    set_in(1'b1, 1'b1, 1'b0, '0, 1'b0);
    repeat (3 * (S + 1)) cycle();

    // A hazard held alongside a branch: branch wins, back-to-back.
    set_in(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
    repeat (3 * (F + 1)) cycle();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle();

    // Halt, hazard and branch together: halt wins, and the halt is sticky.
    set_in(1'b1, 1'b1, 1'b1, 16'h0BAD, 1'b1);
    cycle();
    check("halt_state", 32'(stateO), 32'h3);
    repeat (20) begin
      rand_inputs();
      cycle();
    end
    check("halt_sticky", 32'(haltF), 32'h1);
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    do_reset();

    // Asynchronous reset in the middle of a stall.
    set_in(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) cycle();
    check("midstall_busy", 32'(stallF), 32'h1);
    do_reset();
    repeat (S + 2) cycle();

    // Asynchronous reset in the middle of a redirect.
    set_in(1'b1, 1'b0, 1'b1, 16'h5555, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    do_reset();
    repeat (F + 2) cycle();

    // Random traffic with occasional resets. Recover from halt after a while.
    halt_age = 0;
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      if (halted) halt_age++;
      if ($urandom_range(299, 0) == 0 || halt_age > 30) begin
        halt_age = 0;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/d2f_hazard_ctrl.md
Name: d2f_hazard_ctrl

Overview:
- Decode-to-fetch feedback controller; drives the reverse direction of the fetch/decode pipeline interface.
- Samples decode-stage events: load-use hazard, taken branch/jump, halt.
- Drives stall, flush and PC-redirect controls back to the fetch stage and the fetch/decode latch.
- Moore FSM with registered outputs and a multi-cycle stall/flush counter.

Parameters:
- STALL_CYCLES, 1, cycles stallF is held per load-use hazard (legal 1..15).
- FLUSH_CYCLES, 1, cycles flushF2D is held per redirect (legal 1..3).
- PC_W, 16, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- validD  in  1  decode stage holds a live instruction.
- hazardD  in  1  load-use hazard detected in decode.
- brTakenD  in  1  branch/jump resolved taken in decode.
- brTargetD  in  PC_W  resolved target PC.
- haltD  in  1  HALT decoded.
- stallF  out  1  hold PC and fetch/decode latch.
- flushF2D  out  1  load NOP bubble into fetch/decode latch.
- redirectF  out  1  fetch loads redirectPCF next edge.
- redirectPCF  out  PC_W  redirect target.
- haltF  out  1  processor halted (sticky).
- stateO  out  2  current FSM state, debug.

Behaviour:
- Reset (rst=0, asynchronous): state RUN; stallF, flushF2D, redirectF, haltF = 0; redirectPCF = 0; counter = 0.
- States: RUN=0, STALL=1, REDIRECT=2, HALT=3. All outputs decode from registered state/counter, so they are glitch-free.
- RUN:
  - Events are qualified by validD. With validD=0, stay in RUN.
  - Priority: haltD > brTakenD > hazardD.
  - haltD -> HALT.
  - brTakenD -> REDIRECT; capture brTargetD into the target register; counter = FLUSH_CYCLES-1.
  - hazardD -> STALL; counter = STALL_CYCLES-1.
- Latency: every response asserts exactly one cycle after the sampling edge.
- STALL:
  - stallF=1; all inputs ignored.
  - Counter decrements each cycle; at counter==0, next state is RUN.
  - stallF is high for exactly STALL_CYCLES cycles.
- REDIRECT:
  - flushF2D=1 for FLUSH_CYCLES cycles.
  - redirectF=1 only in the first REDIRECT cycle; redirectPCF = captured target, held stable until the next capture.
  - All inputs ignored, so a second branch while flushing has no effect.
  - Exits to RUN when counter==0.
- HALT:
  - stallF=1, haltF=1, flushF2D=0, redirectF=0.
  - Terminal state; only reset leaves it.
- Back-to-back events: an event sampled on the RUN-return cycle is accepted. No idle cycle is required between events.
- Reset mid-STALL or mid-REDIRECT: immediate return to reset values. No partial redirect is issued after release.
- Counter width is 4 bits. Parameter values outside the legal range are unsupported; an elaboration-time check flags them.

Optional Feature:
- Macro: D2F_HAZARD_STATS_EN.
- Defined:
  - Adds outputs stallCntO[15:0] and flushCntO[15:0].
  - stallCntO increments on each RUN->STALL entry; flushCntO increments on each RUN->REDIRECT entry.
  - Both counters saturate at 16'hFFFF, reset to 0, and freeze in HALT.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset release, validD=0 for 10 cycles -> stateO=0; all outputs 0; redirectPCF=16'h0000.
- STALL_CYCLES=2, pulse validD&hazardD at cycle t -> stallF=1 in cycles t+1..t+2; state RUN at t+3; no flush or redirect.
- validD&brTakenD with brTargetD=16'h0040, FLUSH_CYCLES=2 -> at t+1: redirectF=1, redirectPCF=16'h0040, flushF2D=1. At t+2: flushF2D=1, redirectF=0. Second branch (target 16'h0080) at t+1 is ignored; redirectPCF stays 16'h0040.
- Same cycle haltD=1, brTakenD=1, hazardD=1 -> HALT; haltF=1, stallF=1 permanently; redirectF never asserts. Later hazard/branch inputs have no effect until rst=0.
- Drop rst low mid-STALL (STALL_CYCLES=8, after 3 cycles) -> stallF=0 asynchronously, before the next clock edge. After release, state RUN and no residual stall.
- With D2F_HAZARD_STATS_EN: 3 hazards and 2 branches -> stallCntO=3, flushCntO=2. Force stallCntO to 16'hFFFF -> stays 16'hFFFF on the next hazard.
